if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'd0: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'd0: instruction value written into the IF/ID register on flush or reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 freeze  input  1  hazard stall from the decode stage; hold PC and IF/ID contents.
REQ-006 branch_taken  input  1  redirect request from the execute stage; also flushes IF/ID.
REQ-007 branch_address  input  32  redirect target byte address.
REQ-008 imem_addr  output  32  fetch address to the instruction memory; combinational copy of the PC register.
REQ-009 imem_data  input  32  instruction returned by the instruction memory for imem_addr, same cycle.
REQ-010 pc_out  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-011 instruction_out  output  32  registered instruction held in IF/ID.
REQ-012 valid_out  output  1  IF/ID holds a real fetched instruction.

Function
REQ-013 The PC register SHALL update once per clock, priority: rst > branch_taken > freeze > sequential.
REQ-014 On branch_taken, next PC SHALL be {branch_address[31:2], 2'b00}; low two bits are ignored.
REQ-015 On freeze without branch_taken, PC SHALL hold.
REQ-016 Otherwise next PC SHALL be PC+4, modulo 2^32 (0xFFFFFFFC -> 0x00000000, no flag).
REQ-017 imem_addr SHALL equal PC with zero added latency; imem_data is captured in the same cycle.
REQ-018 The IF/ID register SHALL update with the same priority as REQ-013.
REQ-019 On branch_taken, the IF/ID register SHALL load pc_out=0, instruction_out=NOP_INSTR, valid_out=0.
REQ-020 On freeze without branch_taken, pc_out, instruction_out and valid_out SHALL hold.
REQ-021 Otherwise the IF/ID register SHALL load pc_out=PC+4, instruction_out=imem_data, valid_out=1.
REQ-022 Fetch-to-IF/ID latency SHALL be one cycle: the instruction at address A appears on instruction_out the cycle after imem_addr=A.
REQ-023 branch_taken with freeze asserted SHALL redirect and flush; freeze is ignored that cycle.
REQ-024 branch_taken to the current PC SHALL still flush IF/ID and reload the PC.
REQ-025 Consecutive branch_taken cycles SHALL each redirect; the last target wins.
REQ-026 No output SHALL be X after the first reset edge.

Reset
REQ-027 On a rising clk edge with rst=1, the block SHALL set PC=RESET_PC, pc_out=0, instruction_out=NOP_INSTR and valid_out=0, regardless of all other inputs.
REQ-028 rst asserted mid-freeze or mid-branch SHALL discard the pending state; the first fetch after release is at RESET_PC.
REQ-029 There SHALL be no asynchronous reset path.

Structure
REQ-030 RESET_PC defaults, NOP_INSTR and the instruction width constant (32) SHALL live in the shared ARM pipeline package.
REQ-031 The PC register and the IF/ID register SHALL each be an instance of one sub-module, pipe_reg: a parameterized-width register with synchronous rst, load enable, flush and flush value.
REQ-032 The instruction memory SHALL remain outside this block, connected through imem_addr and imem_data.

Verification
REQ-033 Reset test: rst high 2 cycles, then low, with memory word 0 = 0xE3A00014. Required response:
- Cycle 1 after release: imem_addr = 0x0.
- Next cycle: instruction_out = 0xE3A00014, pc_out = 0x4, valid_out = 1.
REQ-034 Sequential fetch test: 5 free-running cycles.
- imem_addr SHALL step 0, 4, 8, 12, 16.
- pc_out SHALL lag imem_addr by one cycle plus 4.
REQ-035 Freeze test: freeze high for 3 cycles at PC=0x14.
- PC SHALL hold at 0x14.
- IF/ID SHALL hold the word fetched from 0x10.
- After freeze drops, the next IF/ID load SHALL carry pc_out = 0x18.
REQ-036 Branch test: branch_taken=1 with branch_address=0x76 while PC=0x98.
- Next cycle: imem_addr = 0x74, valid_out = 0, instruction_out = NOP_INSTR.
- Following cycle: pc_out = 0x78.
REQ-037 Priority and wrap test: freeze=1 and branch_taken=1 to 0x100.
- PC SHALL become 0x100 and IF/ID SHALL flush.
- Separately, PC=0xFFFFFFFC SHALL advance to 0x0.
REQ-038 Reset mid-branch test: rst and branch_taken both high.
- PC SHALL become RESET_PC, not the branch target.
- valid_out SHALL be 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared ARM pipeline constants and the IF/ID register layout.
package if_stage_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC  = '0;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = '0;

  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } ifid_t;

  localparam int unsigned IFID_W = $bits(ifid_t);

  // Instructions are word aligned; branch targets drop their byte offset.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

  function automatic ifid_t ifid_bubble(input logic [INSTR_W-1:0] nop);
    ifid_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.instr = nop;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_pipe_reg.sv
// Parameterized pipeline register: synchronous reset > flush > load > hold.
module pipe_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] flush_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = flush_val_i;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_address,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] pc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               valid_out
);

  localparam ifid_t IFID_BUBBLE = ifid_bubble(NOP_INSTR);

  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] pc_plus4;
  logic [INSTR_W-1:0] branch_target;
  ifid_t              ifid_q;
  ifid_t              ifid_d;
  logic               unused_addr_lsbs;

  assign pc_plus4         = pc_q + PC_STEP;
  assign branch_target    = word_align(branch_address);
  assign unused_addr_lsbs = ^branch_address[1:0];

  always_comb begin
    ifid_d       = '0;
    ifid_d.valid = 1'b1;
    ifid_d.pc    = pc_plus4;
    ifid_d.instr = imem_data;
  end

  // A branch overrides freeze in both registers, so freeze only gates the load.
  pipe_reg #(
    .WIDTH     (INSTR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (!freeze),
    .flush_i     (branch_taken),
    .flush_val_i (branch_target),
    .d_i         (pc_plus4),
    .q_o         (pc_q)
  );

  pipe_reg #(
    .WIDTH     (IFID_W),
    .RESET_VAL (IFID_BUBBLE)
  ) u_ifid_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (!freeze),
    .flush_i     (branch_taken),
    .flush_val_i (IFID_BUBBLE),
    .d_i         (ifid_d),
    .q_o         (ifid_q)
  );

  assign imem_addr       = pc_q;
  assign pc_out          = ifid_q.pc;
  assign instruction_out = ifid_q.instr;
  assign valid_out       = ifid_q.valid;

endmodule
